// File: rtl/turn_sequencer.sv
// One player turn of the 4x4 card-matching game: cursor moves, two picks,
// settle/compare/reveal timing against the score counter, then selection clear.
module turn_sequencer #(
  parameter int REVEAL_CYCLES = 50000000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        NewKB,
  input  logic [7:0]  KB_DAT,
  input  logic [15:0] flip,
  input  logic        gameend,
  output logic [3:0]  cursor,
  output logic [3:0]  data1,
  output logic [3:0]  data2,
  output logic        cmp_go,
  output logic        datareset,
  output logic [15:0] face_up,
  output logic        sel_err,
  output logic        busy
);
  localparam int CNT_MAX = (REVEAL_CYCLES > SETTLE_CYCLES) ? REVEAL_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] REVEAL_END = CW'(REVEAL_CYCLES - 1);

  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [7:0] K_LEFT  = 8'h6B;
  localparam logic [7:0] K_RIGHT = 8'h74;
  localparam logic [7:0] K_SPACE = 8'h29;
  localparam logic [7:0] K_ENTER = 8'h5A;

  typedef enum logic [2:0] {
    S_PICK1, S_PICK2, S_READY, S_SETTLE, S_REVEAL, S_CLEAR, S_DONE
  } state_t;

  state_t        state, state_d;
  logic [3:0]    cursor_d, data1_d, data2_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          brk, brk_d;
  logic          cmp_go_d, sel_err_d;
  logic          key, picking, cur_flipped;
  logic          show1, show2;

  // A byte after F0 is the release code of a key and never acts
  assign key         = NewKB && !brk && (KB_DAT != K_BRK) && (KB_DAT != K_EXT);
  assign picking     = (state == S_PICK1) || (state == S_PICK2);
  assign cur_flipped = flip[{cursor[1:0], cursor[3:2]}];

  always_comb begin
    state_d   = state;
    cursor_d  = cursor;
    data1_d   = data1;
    data2_d   = data2;
    cnt_d     = cnt;
    brk_d     = brk;
    cmp_go_d  = 1'b0;
    sel_err_d = 1'b0;

    if (NewKB) begin
      if (brk)                  brk_d = 1'b0;
      else if (KB_DAT == K_BRK) brk_d = 1'b1;
    end

    if (picking && key && !gameend) begin
      case (KB_DAT)
        K_UP:    cursor_d[1:0] = cursor[1:0] - 2'd1;
        K_DOWN:  cursor_d[1:0] = cursor[1:0] + 2'd1;
        K_LEFT:  cursor_d[3:2] = cursor[3:2] - 2'd1;
        K_RIGHT: cursor_d[3:2] = cursor[3:2] + 2'd1;
        default: ;
      endcase
    end

    case (state)
      S_PICK1: begin
        if (gameend) state_d = S_DONE;
        else if (key && KB_DAT == K_SPACE) begin
          if (cur_flipped) sel_err_d = 1'b1;
          else begin
            data1_d = cursor;
            state_d = S_PICK2;
          end
        end
      end
      S_PICK2: begin
        if (gameend) state_d = S_DONE;
        else if (key && KB_DAT == K_SPACE) begin
          if (cur_flipped || cursor == data1) sel_err_d = 1'b1;
          else begin
            data2_d = cursor;
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (gameend) state_d = S_DONE;
        else if (key && KB_DAT == K_ENTER) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_END) begin
          cnt_d    = '0;
          cmp_go_d = 1'b1;
          state_d  = S_REVEAL;
        end else cnt_d = cnt + CW'(1);
      end
      S_REVEAL: begin
        if (cnt == REVEAL_END) begin
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else cnt_d = cnt + CW'(1);
      end
      S_CLEAR: state_d = gameend ? S_DONE : S_PICK1;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_PICK1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_PICK1;
      cursor  <= '0;
      data1   <= '0;
      data2   <= '0;
      cnt     <= '0;
      brk     <= 1'b0;
      cmp_go  <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      state   <= state_d;
      cursor  <= cursor_d;
      data1   <= data1_d;
      data2   <= data2_d;
      cnt     <= cnt_d;
      brk     <= brk_d;
      cmp_go  <= cmp_go_d;
      sel_err <= sel_err_d;
    end
  end

  assign datareset = (state == S_CLEAR);
  assign busy      = (state == S_SETTLE) || (state == S_REVEAL) || (state == S_CLEAR);
  assign show1     = (state != S_PICK1) && (state != S_DONE);
  assign show2     = show1 && (state != S_PICK2);

  // Picks are stored as {col,row}; card bit index is {row,col}
  for (genvar i = 0; i < 16; i++) begin : g_card
    assign face_up[i] = flip[i]
                      | (show1 && ({data1[1:0], data1[3:2]} == 4'(i)))
                      | (show2 && ({data2[1:0], data2[3:2]} == 4'(i)));
  end
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Sequences one player turn of the 4x4 card-matching game: moves a keyboard cursor, picks two distinct face-down cards, drives the pair to the compare/score counter, holds both cards face-up for a reveal time, then clears the selection.
- Sits between the PS/2 keyboard decoder (NewKB/KB_DAT) and the compare/score counter.
- Replaces the raw Enter-key strobe to the counter with a qualified one-cycle cmp_go.

Parameters:
- REVEAL_CYCLES, 50000000, clock cycles both picked cards stay visible after a compare (1 s at 50 MHz); counter is 26 bits.
- SETTLE_CYCLES, 2, cycles data1/data2 are held stable before cmp_go (covers the counter's registered memory lookup).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- NewKB  in  1  one-cycle strobe: new scan-code byte on KB_DAT
- KB_DAT  in  8  PS/2 set-2 scan-code byte
- flip  in  16  matched-card mask from the score counter, bit i = card i
- gameend  in  1  game-over level from the score counter
- cursor  out  4  cursor position, encoded {col[1:0],row[1:0]}
- data1  out  4  first picked card, same encoding
- data2  out  4  second picked card, same encoding
- cmp_go  out  1  one-cycle compare strobe to the score counter
- datareset  out  1  one-cycle pulse when the selection is cleared
- face_up  out  16  cards to draw face-up: flip | picked cards
- sel_err  out  1  one-cycle pulse on a rejected select
- busy  out  1  high in S_SETTLE, S_REVEAL and S_CLEAR

Behaviour:
- Card index: i = {row,col} = {code[1:0],code[3:2]}. Example: code 4'b0100 is card 1.
- Reset values (asynchronous): state S_PICK1, cursor 0, data1 0, data2 0, all pulses 0, face_up = flip, reveal counter 0, break flag 0.
- Key filter, applied on NewKB only:
  - A byte 8'hF0 sets the break flag. The next byte is discarded and clears the flag.
  - A byte 8'hE0 is ignored and does not touch the flag.
  - Every other byte is a keypress.
- Cursor keys: up 8'h75 (row-1), down 8'h72 (row+1), left 8'h6B (col-1), right 8'h74 (col+1).
  - Each axis wraps modulo 4: row 0 up goes to row 3; col 3 right goes to col 0.
  - Cursor keys are accepted in S_PICK1 and S_PICK2 only. In all other states they are ignored.
  - The cursor updates on the clock after NewKB.
- Select key: space 8'h29.
  - S_PICK1: if flip[cursor] = 0, load data1 = cursor and go to S_PICK2; otherwise pulse sel_err and stay.
  - S_PICK2: if flip[cursor] = 1 or cursor == data1, pulse sel_err and stay. Otherwise load data2 = cursor and go to S_READY.
- Confirm key: Enter 8'h5A.
  - Accepted only in S_READY; go to S_SETTLE.
  - Enter in S_PICK1 or S_PICK2 is ignored.
- S_SETTLE: count SETTLE_CYCLES cycles, then pulse cmp_go for exactly one cycle and go to S_REVEAL.
- S_REVEAL: count REVEAL_CYCLES cycles, then go to S_CLEAR. All keys are ignored.
- S_CLEAR: pulse datareset for one cycle, keep data1/data2 unchanged, go to S_PICK1 (or S_DONE if gameend is high).
- S_DONE: absorbing state; only reset leaves it. cmp_go is never asserted here.
- gameend high in S_PICK1, S_PICK2 or S_READY goes to S_DONE on the next clock.
- face_up:
  - flip in S_PICK1 and S_DONE.
  - flip | bit(data1) in S_PICK2.
  - flip | bit(data1) | bit(data2) in S_READY, S_SETTLE, S_REVEAL and S_CLEAR.
- Outputs hold: data1/data2 stay constant from S_READY entry through S_CLEAR.
- Simultaneous events: a key strobe and a counter expiry in the same cycle give the counter priority; the key is dropped.
- Reset mid-turn aborts immediately to the reset values; no cmp_go or datareset is emitted.

Test Plan:
- Reset, then NewKB bytes 8'h74, 8'h74, 8'h72 -> cursor = 4'b1001 (col 2, row 1). Then 8'h6B x3 -> col wraps to 3, cursor = 4'b1101.
- At cursor 0: space, move right, space, Enter -> data1 = 0, data2 = 4'b0100, face_up[1:0] = 2'b11. cmp_go is high exactly SETTLE_CYCLES+1 clocks after Enter is registered; after REVEAL_CYCLES, datareset pulses and state returns to S_PICK1.
- flip[5] = 1, cursor = 4'b0101, space -> sel_err pulse, still S_PICK1. Pick card 0, then space again on card 0 -> sel_err, still S_PICK2.
- Byte sequence F0 29 (a release) in S_PICK1 -> no selection, no sel_err. E0 75 -> cursor row decrements once.
- Enter pressed during S_REVEAL -> ignored, exactly one cmp_go per turn. gameend high in S_CLEAR -> S_DONE, and later Enter or space produce no cmp_go.
- reset asserted during S_SETTLE -> no cmp_go, outputs at reset values within the same cycle.
